inventory_tracker: RTL and testbench

- Parametrised successor to the vending datapath's inventory monitor. Holds the per-slot item counts in internal registers instead of taking them from a caller-supplied vector.
- Serves dispense requests from the controller FSM over a 4-phase req/done handshake. Accepts restock writes.
- Publishes per-slot empty status and the availability of the currently selected slot. Sits between the controller FSM and the dispense actuator.

---
 rtl/inventory_pkg.sv | 20 ++
 rtl/inventory_slot_array.sv | 64 ++++++
 rtl/inventory_tracker.sv | 136 +++++++++++++
 tb/tb_inventory_tracker.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inventory_pkg.sv
// Shared types and defaults for the inventory tracker slice.
package inventory_pkg;

  localparam int DEF_NUM_SLOTS = 8;
  localparam int DEF_COUNT_W   = 3;

  typedef logic [DEF_COUNT_W-1:0] count_t;

  typedef enum logic [1:0] {
    IDLE,
    DEC,
    ACK
  } state_t;

  // Slot index width never drops below one bit, even for a single slot.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/inventory_slot_array.sv
// Per-slot count register file: one write port, two combinational read ports, status vectors.
// Low-stock vector exists only when LOW_STOCK_EN is defined.
module inventory_slot_array
  import inventory_pkg::*;
#(
  parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter int COUNT_W    = DEF_COUNT_W,
  parameter int IDX_W      = idx_width(NUM_SLOTS),
  parameter int LOW_THRESH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [IDX_W-1:0]     waddr,
  input  logic [COUNT_W-1:0]   wdata,
  input  logic [IDX_W-1:0]     dec_addr,
  output logic [COUNT_W-1:0]   dec_count,
  input  logic [IDX_W-1:0]     sel_addr,
  output logic [COUNT_W-1:0]   sel_count,
  output logic [NUM_SLOTS-1:0] empty_vec
`ifdef LOW_STOCK_EN
  ,
  output logic [NUM_SLOTS-1:0] low_vec
`endif
);

  localparam logic [IDX_W:0] SLOT_LIMIT = (IDX_W + 1)'(NUM_SLOTS);

  logic [COUNT_W-1:0] count_q [NUM_SLOTS];

  logic waddr_ok;
  logic dec_addr_ok;
  logic sel_addr_ok;

  assign waddr_ok    = ({1'b0, waddr} < SLOT_LIMIT);
  assign dec_addr_ok = ({1'b0, dec_addr} < SLOT_LIMIT);
  assign sel_addr_ok = ({1'b0, sel_addr} < SLOT_LIMIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        count_q[i] <= '0;
      end
    end else if (we && waddr_ok) begin
      count_q[waddr] <= wdata;
    end
  end

  // Out-of-range reads return zero so callers see them as empty slots.
  assign dec_count = dec_addr_ok ? count_q[dec_addr] : '0;
  assign sel_count = sel_addr_ok ? count_q[sel_addr] : '0;

`ifdef LOW_STOCK_EN
  localparam logic [COUNT_W-1:0] THRESH = COUNT_W'(LOW_THRESH);
`endif

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_status
    assign empty_vec[i] = (count_q[i] == '0);
`ifdef LOW_STOCK_EN
    assign low_vec[i] = (count_q[i] != '0) && (count_q[i] <= THRESH);
`endif
  end

endmodule

// File: rtl/inventory_tracker.sv
// Inventory tracker: per-slot counts, 4-phase dispense handshake, restock writes, registered status.
// Optional low-stock mask enabled by defining LOW_STOCK_EN.
module inventory_tracker
  import inventory_pkg::*;
#(
  parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter int COUNT_W    = DEF_COUNT_W,
  parameter int IDX_W      = idx_width(NUM_SLOTS),
  parameter int LOW_THRESH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     sel_index,
  input  logic                 dispense_req,
  output logic                 dispense_done,
  output logic                 dispense_err,
  input  logic                 restock_valid,
  input  logic [IDX_W-1:0]     restock_index,
  input  logic [COUNT_W-1:0]   restock_count,
  output logic                 restock_ready,
  output logic                 item_available,
  output logic [NUM_SLOTS-1:0] empty_mask,
  output logic [NUM_SLOTS-1:0] low_stock_mask
);

  state_t               state;
  logic [IDX_W-1:0]     idx_q;
  logic                 err_q;
  logic [COUNT_W-1:0]   dec_count;
  logic [COUNT_W-1:0]   sel_count;
  logic [NUM_SLOTS-1:0] empty_vec;
  logic                 dec_ok;
  logic                 we;
  logic [IDX_W-1:0]     waddr;
  logic [COUNT_W-1:0]   wdata;

  // Out-of-range slots read as zero, so one test covers both refusal causes.
  assign dec_ok        = (dec_count != '0);
  assign restock_ready = (state != DEC);

  always_comb begin
    we    = 1'b0;
    waddr = restock_index;
    wdata = restock_count;
    if (state == DEC) begin
      we    = dec_ok;
      waddr = idx_q;
      wdata = dec_count - COUNT_W'(1);
    end else if (restock_valid) begin
      we = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      idx_q         <= '0;
      err_q         <= 1'b0;
      dispense_done <= 1'b0;
      dispense_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          dispense_done <= 1'b0;
          dispense_err  <= 1'b0;
          if (dispense_req) begin
            idx_q <= sel_index;
            state <= DEC;
          end
        end
        DEC: begin
          err_q <= !dec_ok;
          state <= ACK;
        end
        ACK: begin
          if (!dispense_req) begin
            dispense_done <= 1'b0;
            dispense_err  <= 1'b0;
            state         <= IDLE;
          end else begin
            dispense_done <= 1'b1;
            dispense_err  <= err_q;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      empty_mask     <= '1;
      item_available <= 1'b0;
    end else begin
      empty_mask     <= empty_vec;
      item_available <= (sel_count != '0);
    end
  end

`ifdef LOW_STOCK_EN
  logic [NUM_SLOTS-1:0] low_vec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      low_stock_mask <= '0;
    end else begin
      low_stock_mask <= low_vec;
    end
  end
`else
  assign low_stock_mask = '0;
`endif

  inventory_slot_array #(
    .NUM_SLOTS (NUM_SLOTS),
    .COUNT_W   (COUNT_W),
    .IDX_W     (IDX_W),
    .LOW_THRESH(LOW_THRESH)
  ) u_slots (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .dec_addr (idx_q),
    .dec_count(dec_count),
    .sel_addr (sel_index),
    .sel_count(sel_count),
    .empty_vec(empty_vec)
`ifdef LOW_STOCK_EN
    ,
    .low_vec  (low_vec)
`endif
  );

endmodule

// File: tb/tb_inventory_tracker.sv
// Directed, table-driven bench for inventory_tracker (8-slot and 6-slot instances).
module tb_inventory_tracker;

  logic       clk;
  logic       rst;
  logic [2:0] sel_index;
  logic       dispense_req;
  logic       dispense_done;
  logic       dispense_err;
  logic       restock_valid;
  logic [2:0] restock_index;
  logic [2:0] restock_count;
  logic       restock_ready;
  logic       item_available;
  logic [7:0] empty_mask;
  logic [7:0] low_stock_mask;

  logic       sel6;
  logic [2:0] sel_index6;
  logic       req6;
  logic       done6;
  logic       err6;
  logic       rv6;
  logic [2:0] ri6;
  logic [2:0] rc6;
  logic       ready6;
  logic       avail6;
  logic [5:0] empty6;
  logic [5:0] low6;

  int checks;
  int errors;

`ifdef LOW_STOCK_EN
  localparam logic LOW_ON = 1'b1;
`else
  localparam logic LOW_ON = 1'b0;
`endif

  inventory_tracker dut (
    .clk           (clk),
    .rst           (rst),
    .sel_index     (sel_index),
    .dispense_req  (dispense_req),
    .dispense_done (dispense_done),
    .dispense_err  (dispense_err),
    .restock_valid (restock_valid),
    .restock_index (restock_index),
    .restock_count (restock_count),
    .restock_ready (restock_ready),
    .item_available(item_available),
    .empty_mask    (empty_mask),
    .low_stock_mask(low_stock_mask)
  );

  inventory_tracker #(.NUM_SLOTS(6)) dut6 (
    .clk           (clk),
    .rst           (rst),
    .sel_index     (sel_index6),
    .dispense_req  (req6),
    .dispense_done (done6),
    .dispense_err  (err6),
    .restock_valid (rv6),
    .restock_index (ri6),
    .restock_count (rc6),
    .restock_ready (ready6),
    .item_available(avail6),
    .empty_mask    (empty6),
    .low_stock_mask(low6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ri;
    logic [2:0] rc;
    logic [2:0] sel;
    logic [7:0] exp_empty;
    logic       exp_avail;
    logic [7:0] exp_low;
  } vec_t;

  vec_t vecs [6];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Restock one slot, then sample status after the following edge.
  task automatic apply_stimulus(input vec_t v, input int n);
    @(negedge clk);
    restock_valid = 1'b1;
    restock_index = v.ri;
    restock_count = v.rc;
    sel_index     = v.sel;
    @(posedge clk);
    @(negedge clk);
    restock_valid = 1'b0;
    @(posedge clk);
    #1;
    check_output($sformatf("vec%0d_empty", n), 32'(empty_mask), 32'(v.exp_empty));
    check_output($sformatf("vec%0d_avail", n), 32'(item_available), 32'(v.exp_avail));
    check_output($sformatf("vec%0d_low", n), 32'(low_stock_mask), 32'(v.exp_low & {8{LOW_ON}}));
    check_output($sformatf("vec%0d_ready", n), 32'(restock_ready), 32'd1);
  endtask

  // Full 4-phase handshake on the 8-slot instance; lat counts edges until done.
  task automatic dispense(input logic [2:0] sel, output logic err, output int lat);
    @(negedge clk);
    sel_index    = sel;
    dispense_req = 1'b1;
    lat          = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      lat = i + 1;
      if (dispense_done) break;
    end
    err = dispense_err;
    @(negedge clk);
    dispense_req = 1'b0;
    @(posedge clk);
    #1;
    check_output("done_release", 32'(dispense_done), 32'd0);
  endtask

  initial begin
    logic err;
    int   lat;
    int   waited;

    checks        = 0;
    errors        = 0;
    rst           = 1'b0;
    sel_index     = '0;
    dispense_req  = 1'b0;
    restock_valid = 1'b0;
    restock_index = '0;
    restock_count = '0;
    sel6          = 1'b0;
    sel_index6    = '0;
    req6          = 1'b0;
    rv6           = 1'b0;
    ri6           = '0;
    rc6           = '0;

    vecs[0] = '{3'd3, 3'd5, 3'd3, 8'hF7, 1'b1, 8'h00};
    vecs[1] = '{3'd0, 3'd1, 3'd0, 8'hF6, 1'b1, 8'h01};
    vecs[2] = '{3'd7, 3'd7, 3'd5, 8'h76, 1'b0, 8'h01};
    vecs[3] = '{3'd0, 3'd0, 3'd0, 8'h77, 1'b0, 8'h00};
    vecs[4] = '{3'd5, 3'd1, 3'd5, 8'h57, 1'b1, 8'h20};
    vecs[5] = '{3'd5, 3'd2, 3'd7, 8'h57, 1'b1, 8'h00};

    @(negedge clk);
    @(negedge clk);
    check_output("rst_done", 32'(dispense_done), 32'd0);
    check_output("rst_err", 32'(dispense_err), 32'd0);
    check_output("rst_avail", 32'(item_available), 32'd0);
    check_output("rst_empty", 32'(empty_mask), 32'hFF);
    check_output("rst_low", 32'(low_stock_mask), 32'd0);
    check_output("rst_empty6", 32'(empty6), 32'h3F);
    rst = 1'b1;

    for (int n = 0; n < 6; n++) begin
      apply_stimulus(vecs[n], n);
    end

    // Counts now: slot3=5, slot5=2, slot7=7, others 0.
    for (int n = 1; n <= 5; n++) begin
      dispense(3'd3, err, lat);
      check_output($sformatf("disp%0d_latency", n), 32'(lat), 32'd3);
      check_output($sformatf("disp%0d_err", n), 32'(err), 32'd0);
      check_output($sformatf("disp%0d_count", n), 32'(dut.u_slots.count_q[3]), 32'(5 - n));
    end
    @(posedge clk);
    #1;
    check_output("slot3_empty", 32'(empty_mask[3]), 32'd1);
    check_output("slot3_unavail", 32'(item_available), 32'd0);

    dispense(3'd3, err, lat);
    check_output("disp6_latency", 32'(lat), 32'd3);
    check_output("disp6_err", 32'(err), 32'd1);
    check_output("disp6_count", 32'(dut.u_slots.count_q[3]), 32'd0);

    // Restock held through a dispense: lands in IDLE, blocked in DEC, lands again in ACK.
    @(negedge clk);
    sel_index     = 3'd3;
    dispense_req  = 1'b1;
    restock_valid = 1'b1;
    restock_index = 3'd3;
    restock_count = 3'd6;
    @(posedge clk);
    #1;
    check_output("dec_ready", 32'(restock_ready), 32'd0);
    check_output("dec_count_pre", 32'(dut.u_slots.count_q[3]), 32'd6);
    @(posedge clk);
    #1;
    check_output("ack_ready", 32'(restock_ready), 32'd1);
    check_output("dec_count_post", 32'(dut.u_slots.count_q[3]), 32'd5);
    @(posedge clk);
    #1;
    check_output("ovr_count", 32'(dut.u_slots.count_q[3]), 32'd6);
    check_output("ovr_done", 32'(dispense_done), 32'd1);
    check_output("ovr_err", 32'(dispense_err), 32'd0);
    @(negedge clk);
    restock_valid = 1'b0;
    dispense_req  = 1'b0;
    @(posedge clk);
    #1;
    check_output("ovr_release", 32'(dispense_done), 32'd0);

    // Six-slot instance: out-of-range restock and dispense.
    @(negedge clk);
    rv6 = 1'b1;
    ri6 = 3'd2;
    rc6 = 3'd3;
    @(negedge clk);
    rv6 = 1'b0;
    @(posedge clk);
    #1;
    check_output("n6_empty", 32'(empty6), 32'h3B);
    @(negedge clk);
    rv6 = 1'b1;
    ri6 = 3'd7;
    rc6 = 3'd5;
    sel_index6 = 3'd7;
    #1;
    check_output("n6_oor_ready", 32'(ready6), 32'd1);
    @(negedge clk);
    rv6 = 1'b0;
    @(posedge clk);
    #1;
    check_output("n6_oor_empty", 32'(empty6), 32'h3B);
    check_output("n6_oor_count", 32'(dut6.u_slots.count_q[2]), 32'd3);
    check_output("n6_oor_avail", 32'(avail6), 32'd0);
    @(negedge clk);
    req6   = 1'b1;
    waited = 0;
    while (!done6 && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_output("n6_oor_done", 32'(done6), 32'd1);
    check_output("n6_oor_err", 32'(err6), 32'd1);
    @(negedge clk);
    req6 = 1'b0;
    @(posedge clk);
    #1;
    check_output("n6_oor_release", 32'(done6), 32'd0);
    check_output("n6_oor_count2", 32'(dut6.u_slots.count_q[2]), 32'd3);

    // Asynchronous reset in the middle of ACK.
    @(negedge clk);
    sel_index    = 3'd7;
    dispense_req = 1'b1;
    waited       = 0;
    while (!dispense_done && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_output("ack_before_rst", 32'(dispense_done), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_output("arst_done", 32'(dispense_done), 32'd0);
    check_output("arst_err", 32'(dispense_err), 32'd0);
    check_output("arst_empty", 32'(empty_mask), 32'hFF);
    check_output("arst_avail", 32'(item_available), 32'd0);
    check_output("arst_count7", 32'(dut.u_slots.count_q[7]), 32'd0);
    check_output("arst_count3", 32'(dut.u_slots.count_q[3]), 32'd0);
    @(negedge clk);
    dispense_req = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    check_output("post_rst_done", 32'(dispense_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
